unfunnel_ctrl_4_2: RTL and testbench



---
 rtl/unfunnel_ctrl_4_2.sv | 134 +++++++++++++
 tb/tb_unfunnel_ctrl_4_2.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/unfunnel_ctrl_4_2.sv
// 4:2 unfunnel: gathers 1/2/4 narrow lanes per beat into an 8-lane wide word
// and presents the buffered word on a single req/ack initiator port.
module unfunnel_ctrl_4_2 #(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             t_0_req,
    output logic             t_0_ack,
    input  logic [W-1:0]     t_0_dat,
    input  logic             t_1_req,
    output logic             t_1_ack,
    input  logic [W-1:0]     t_1_dat,
    input  logic             t_2_req,
    output logic             t_2_ack,
    input  logic [W-1:0]     t_2_dat,
    input  logic             t_3_req,
    output logic             t_3_ack,
    input  logic [W-1:0]     t_3_dat,
    input  logic             t_cfg_req,
    output logic             t_cfg_ack,
    output logic             i_0_req,
    input  logic             i_0_ack,
    output logic [8*W-1:0]   i_0_dat,
    output logic [7:0]       sel,
    input  logic [7:0]       mode
);

    localparam int unsigned LANES = 8;
    localparam int unsigned TGTS  = 4;
    localparam int unsigned SW    = 3;

    logic [SW-1:0]   r_state;
    logic            r_full;
    logic [W-1:0]    r_lane [LANES];

    logic [SW-1:0]   w_n;
    logic [TGTS-1:0] w_active;
    logic [TGTS-1:0] w_req;
    logic [TGTS-1:0] w_ack;
    logic [W-1:0]    w_dat [TGTS];
    logic [SW-1:0]   w_idx [TGTS];
    logic [SW-1:0]   w_next_state;
    logic            w_space;
    logic            w_accept;
    logic            w_last;
    logic            w_unused;

    // Expand decode, lowest set mode bit wins
    always_comb begin
        w_n      = '0;
        w_active = '0;
        if (mode[0]) begin
            w_n      = SW'(1);
            w_active = 4'b0001;
        end else if (mode[1]) begin
            w_n      = SW'(2);
            w_active = 4'b0011;
        end else if (mode[2]) begin
            w_n      = SW'(4);
            w_active = 4'b1111;
        end
    end

    assign w_unused = ^{mode[7:3], t_cfg_req};

    assign w_req    = {t_3_req, t_2_req, t_1_req, t_0_req};
    assign w_dat[0] = t_0_dat;
    assign w_dat[1] = t_1_dat;
    assign w_dat[2] = t_2_dat;
    assign w_dat[3] = t_3_dat;

    // A beat is taken only when every active lane requests and the buffer can take it
    assign w_space      = ~r_full | i_0_ack;
    assign w_accept     = (|w_active) & (&(w_req | ~w_active)) & w_space;
    assign w_next_state = r_state + w_n;
    assign w_last       = w_accept & (w_next_state == '0);
    assign w_ack        = w_accept ? w_active : '0;

    assign t_0_ack = w_ack[0];
    assign t_1_ack = w_ack[1];
    assign t_2_ack = w_ack[2];
    assign t_3_ack = w_ack[3];

    always_comb begin
        for (int unsigned k = 0; k < TGTS; k++) begin
            w_idx[k] = r_state + SW'(k);
        end
    end

    // Beat offset and output-word valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= w_next_state;
            end
            if (w_last) begin
                r_full <= 1'b1;
            end else if (i_0_ack && r_full) begin
                r_full <= 1'b0;
            end
        end
    end

    // Lane capture into the wide buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                r_lane[l] <= '0;
            end
        end else if (w_accept) begin
            for (int unsigned k = 0; k < TGTS; k++) begin
                if (w_active[k]) begin
                    r_lane[w_idx[k]] <= w_dat[k];
                end
            end
        end
    end

    always_comb begin
        i_0_dat = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            i_0_dat[l*W +: W] = r_lane[l];
        end
    end

    assign i_0_req   = r_full;
    assign sel       = {5'b0, r_state[0], r_state[1], r_state[2]};
    assign t_cfg_ack = (r_state == '0) & ~r_full;

endmodule

// File: tb/tb_unfunnel_ctrl_4_2.sv
// Directed bench for unfunnel_ctrl_4_2: inputs driven on the falling edge,
// outputs checked 1ns later with immediate assertions.
module tb_unfunnel_ctrl_4_2;

    localparam int unsigned W = 32;

    logic           clk;
    logic           reset_n;
    logic           t_0_req, t_1_req, t_2_req, t_3_req;
    logic           t_0_ack, t_1_ack, t_2_ack, t_3_ack;
    logic [W-1:0]   t_0_dat, t_1_dat, t_2_dat, t_3_dat;
    logic           t_cfg_req, t_cfg_ack;
    logic           i_0_req, i_0_ack;
    logic [8*W-1:0] i_0_dat;
    logic [7:0]     sel;
    logic [7:0]     mode;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8*W-1:0] exp_word;
    logic [7:0]     sel_m1 [8];

    unfunnel_ctrl_4_2 #(.W(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .t_0_req(t_0_req), .t_0_ack(t_0_ack), .t_0_dat(t_0_dat),
        .t_1_req(t_1_req), .t_1_ack(t_1_ack), .t_1_dat(t_1_dat),
        .t_2_req(t_2_req), .t_2_ack(t_2_ack), .t_2_dat(t_2_dat),
        .t_3_req(t_3_req), .t_3_ack(t_3_ack), .t_3_dat(t_3_dat),
        .t_cfg_req(t_cfg_req), .t_cfg_ack(t_cfg_ack),
        .i_0_req(i_0_req), .i_0_ack(i_0_ack), .i_0_dat(i_0_dat),
        .sel(sel), .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*W-1:0] word_of(input logic [W-1:0] base);
        logic [8*W-1:0] w;
        w = '0;
        for (int l = 0; l < 8; l++) w[l*W +: W] = base + W'(l);
        return w;
    endfunction

    function automatic logic [3:0] acks();
        return {t_3_ack, t_2_ack, t_1_ack, t_0_ack};
    endfunction

    task automatic set_reqs(input logic [3:0] r);
        {t_3_req, t_2_req, t_1_req, t_0_req} = r;
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        sel_m1[0] = 8'h00; sel_m1[1] = 8'h04; sel_m1[2] = 8'h02; sel_m1[3] = 8'h06;
        sel_m1[4] = 8'h01; sel_m1[5] = 8'h05; sel_m1[6] = 8'h03; sel_m1[7] = 8'h07;

        reset_n = 1'b0; mode = 8'h00; i_0_ack = 1'b0; t_cfg_req = 1'b0;
        set_reqs(4'b0000);
        t_0_dat = '0; t_1_dat = '0; t_2_dat = '0; t_3_dat = '0;
        next_cyc(); next_cyc();
        #1;
        chk("rst_i0req", 256'(i_0_req), 256'(1'b0));
        chk("rst_sel", 256'(sel), 256'(8'h00));
        chk("rst_cfg", 256'(t_cfg_ack), 256'(1'b1));
        chk("rst_acks", 256'(acks()), 256'(4'b0000));
        chk("rst_dat", i_0_dat, '0);

        // Mode 4: two beats
        next_cyc();
        reset_n = 1'b1; mode = 8'h04; i_0_ack = 1'b1; set_reqs(4'b1111);
        t_0_dat = 32'hA000_0000; t_1_dat = 32'hA000_0001;
        t_2_dat = 32'hA000_0002; t_3_dat = 32'hA000_0003;
        #1;
        chk("m4_b0_acks", 256'(acks()), 256'(4'b1111));
        chk("m4_b0_sel", 256'(sel), 256'(8'h00));
        next_cyc();
        t_0_dat = 32'hA000_0004; t_1_dat = 32'hA000_0005;
        t_2_dat = 32'hA000_0006; t_3_dat = 32'hA000_0007;
        #1;
        chk("m4_b1_acks", 256'(acks()), 256'(4'b1111));
        chk("m4_b1_sel", 256'(sel), 256'(8'h01));
        chk("m4_b1_cfg", 256'(t_cfg_ack), 256'(1'b0));
        chk("m4_b1_i0req", 256'(i_0_req), 256'(1'b0));
        next_cyc();
        set_reqs(4'b0000);
        #1;
        chk("m4_i0req", 256'(i_0_req), 256'(1'b1));
        chk("m4_dat", i_0_dat, word_of(32'hA000_0000));
        chk("m4_cfg_full", 256'(t_cfg_ack), 256'(1'b0));
        next_cyc();
        #1;
        chk("m4_drained", 256'(i_0_req), 256'(1'b0));
        chk("m4_cfg_back", 256'(t_cfg_ack), 256'(1'b1));

        // Mode 1: eight beats, lanes 1..3 request but must never be acked
        mode = 8'h01;
        for (int b = 0; b < 8; b++) begin
            set_reqs(4'b1111);
            t_0_dat = 32'h10 + W'(b);
            #1;
            chk($sformatf("m1_sel_%0d", b), 256'(sel), 256'(sel_m1[b]));
            chk($sformatf("m1_acks_%0d", b), 256'(acks()), 256'(4'b0001));
            next_cyc();
        end
        set_reqs(4'b0000);
        #1;
        chk("m1_i0req", 256'(i_0_req), 256'(1'b1));
        chk("m1_dat", i_0_dat, word_of(32'h10));
        next_cyc();

        // Mode 2: fill, then stall the initiator for 5 cycles
        mode = 8'h02; i_0_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            set_reqs(4'b1111);
            t_0_dat = 32'hB0 + W'(2*b); t_1_dat = 32'hB1 + W'(2*b);
            #1;
            chk($sformatf("m2_acks_%0d", b), 256'(acks()), 256'(4'b0011));
            next_cyc();
        end
        t_0_dat = 32'hC0; t_1_dat = 32'hC1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall_acks_%0d", c), 256'(acks()), 256'(4'b0000));
            chk($sformatf("stall_dat_%0d", c), i_0_dat, word_of(32'hB0));
            chk($sformatf("stall_i0req_%0d", c), 256'(i_0_req), 256'(1'b1));
            next_cyc();
        end
        i_0_ack = 1'b1;
        #1;
        chk("release_acks", 256'(acks()), 256'(4'b0011));
        chk("release_dat", i_0_dat, word_of(32'hB0));
        next_cyc();
        i_0_ack = 1'b0; set_reqs(4'b0000);
        exp_word = word_of(32'hB0);
        exp_word[0 +: W] = 32'hC0;
        exp_word[W +: W] = 32'hC1;
        #1;
        chk("post_rel_i0req", 256'(i_0_req), 256'(1'b0));
        chk("post_rel_sel", 256'(sel), 256'(8'h02));
        chk("post_rel_dat", i_0_dat, exp_word);

        // Partial request set: no acks, no progress
        set_reqs(4'b0001); t_0_dat = 32'hC2; t_1_dat = 32'hC3;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("part_acks_%0d", c), 256'(acks()), 256'(4'b0000));
            chk($sformatf("part_sel_%0d", c), 256'(sel), 256'(8'h02));
            next_cyc();
        end
        set_reqs(4'b0011);
        #1;
        chk("part_full_acks", 256'(acks()), 256'(4'b0011));
        next_cyc();
        t_0_dat = 32'hC4; t_1_dat = 32'hC5;
        #1;
        chk("part_sel_next", 256'(sel), 256'(8'h01));
        chk("c45_acks", 256'(acks()), 256'(4'b0011));
        next_cyc();
        t_0_dat = 32'hC6; t_1_dat = 32'hC7;
        #1;
        chk("c67_acks", 256'(acks()), 256'(4'b0011));
        next_cyc();
        set_reqs(4'b0000);
        #1;
        chk("c_i0req", 256'(i_0_req), 256'(1'b1));
        chk("c_dat", i_0_dat, word_of(32'hC0));
        i_0_ack = 1'b1;
        next_cyc();
        i_0_ack = 1'b0;
        #1;
        chk("c_drained", 256'(i_0_req), 256'(1'b0));
        chk("c_cfg", 256'(t_cfg_ack), 256'(1'b1));

        // Mode 0: nothing is ever accepted
        mode = 8'h00; set_reqs(4'b1111);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("m0_acks_%0d", c), 256'(acks()), 256'(4'b0000));
            chk($sformatf("m0_i0req_%0d", c), 256'(i_0_req), 256'(1'b0));
            chk($sformatf("m0_sel_%0d", c), 256'(sel), 256'(8'h00));
            next_cyc();
        end

        // Mode 1: partial word, then asynchronous reset
        mode = 8'h01; i_0_ack = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_reqs(4'b0001); t_0_dat = 32'h30 + W'(b);
            next_cyc();
        end
        set_reqs(4'b0000);
        #1;
        chk("pre_rst_sel", 256'(sel), 256'(8'h06));
        chk("pre_rst_cfg", 256'(t_cfg_ack), 256'(1'b0));
        reset_n = 1'b0;
        #1;
        chk("arst_sel", 256'(sel), 256'(8'h00));
        chk("arst_i0req", 256'(i_0_req), 256'(1'b0));
        chk("arst_cfg", 256'(t_cfg_ack), 256'(1'b1));
        next_cyc();
        reset_n = 1'b1;
        for (int b = 0; b < 8; b++) begin
            set_reqs(4'b0001); t_0_dat = 32'h40 + W'(b);
            #1;
            chk($sformatf("rr_sel_%0d", b), 256'(sel), 256'(sel_m1[b]));
            next_cyc();
        end
        set_reqs(4'b0000);
        #1;
        chk("rr_i0req", 256'(i_0_req), 256'(1'b1));
        chk("rr_dat", i_0_dat, word_of(32'h40));
        next_cyc();
        #1;
        chk("rr_drained", 256'(i_0_req), 256'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
